// File: rtl/boot_loader_arb.sv
// Boot loader / memory port arbiter: streams a length-prefixed image from the UART RX FIFO into RAM,
// then hands the data port to the CPU. Optional trailer check under BOOT_LOADER_CHECKSUM_EN.
module boot_loader_arb #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100,
    parameter int unsigned MAX_WORDS = 32768
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_en,
    input  logic        empty,
    input  logic [7:0]  uart_in,
    output logic        rdreq,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_writedata,
    input  logic        cpu_writectrl,
    input  logic        cpu_readctrl,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writedata,
    output logic        mem_writectrl,
    output logic        mem_readctrl,
    output logic        mem_empty,
    output logic        clken,
    output logic        busy,
    output logic        err
);

    localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StRun,
`ifdef BOOT_LOADER_CHECKSUM_EN
        StCsum,
`endif
        StErr
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] len_q, len_d;
    logic [31:0] word_q, word_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] assembled;
    logic        last_byte;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            len_q      <= 32'd0;
            word_q     <= 32'd0;
            wr_addr_q  <= BASE_ADDR;
            word_cnt_q <= 32'd0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q     <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            word_q     <= word_d;
            wr_addr_q  <= wr_addr_d;
            word_cnt_q <= word_cnt_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        len_d         = len_q;
        word_d        = word_q;
        wr_addr_d     = wr_addr_q;
        word_cnt_d    = word_cnt_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        rdreq         = 1'b0;
        mem_addr      = wr_addr_q;
        mem_writedata = word_q;
        mem_writectrl = 1'b0;
        mem_readctrl  = 1'b0;
        mem_empty     = 1'b1;
        clken         = 1'b0;
        busy          = 1'b1;
        err           = 1'b0;
        last_byte     = (byte_cnt_q == 2'd3);
        // Full little-endian value as it will stand once the current head byte lands in the top lane.
        assembled     = {uart_in, word_q[23:0]};

        unique case (state_q)
            StIdle: begin
                byte_cnt_d = 2'd0;
                word_cnt_d = 32'd0;
                wr_addr_d  = BASE_ADDR;
`ifdef BOOT_LOADER_CHECKSUM_EN
                csum_d     = 32'd0;
`endif
                state_d    = boot_en ? StLen : StRun;
            end
            StLen: begin
                rdreq     = ~empty;
                assembled = {uart_in, len_q[23:0]};
                if (!empty) begin
                    len_d[{byte_cnt_q, 3'b000} +: 8] = uart_in;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        len_d = assembled;
                        if (assembled == 32'd0) begin
                            state_d = StRun;
                        end else if (assembled > MaxWords) begin
                            state_d = StErr;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                rdreq = ~empty;
                if (!empty) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = uart_in;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                mem_writectrl = 1'b1;
                wr_addr_d     = wr_addr_q + 32'd4;
                word_cnt_d    = word_cnt_q + 32'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                csum_d        = csum_q ^ word_q;
                state_d       = (word_cnt_q + 32'd1 == len_q) ? StCsum : StData;
`else
                state_d       = (word_cnt_q + 32'd1 == len_q) ? StRun : StData;
`endif
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            StCsum: begin
                rdreq = ~empty;
                if (!empty) begin
                    word_d[{byte_cnt_q, 3'b000} +: 8] = uart_in;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte) begin
                        state_d = (assembled == csum_q) ? StRun : StErr;
                    end
                end
            end
`endif
            StRun: begin
                mem_addr      = cpu_addr;
                mem_writedata = cpu_writedata;
                mem_writectrl = cpu_writectrl;
                mem_readctrl  = cpu_readctrl;
                mem_empty     = empty;
                clken         = 1'b1;
                busy          = 1'b0;
            end
            StErr: begin
                err  = 1'b1;
                busy = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_loader_arb.sv
// Self-checking bench for boot_loader_arb: scripted and random images fed through a stalling FIFO model.
module tb_boot_loader_arb;

    localparam logic [31:0] BASE = 32'h0000_0100;
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam int CsumCyc = 4;
`else
    localparam int CsumCyc = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_en;
    logic        empty;
    logic [7:0]  uart_in;
    logic        rdreq;
    logic [31:0] cpu_addr, cpu_writedata;
    logic        cpu_writectrl, cpu_readctrl;
    logic [31:0] mem_addr, mem_writedata;
    logic        mem_writectrl, mem_readctrl, mem_empty;
    logic        clken, busy, err;

    int checks = 0;
    int failures = 0;
    logic [7:0]  img[$];
    logic [31:0] words[$];
    bit          bad_trailer = 1'b0;

    boot_loader_arb #(.BASE_ADDR(BASE), .MAX_WORDS(32768)) dut (
        .clk(clk), .rst_n(rst_n), .boot_en(boot_en), .empty(empty), .uart_in(uart_in),
        .rdreq(rdreq), .cpu_addr(cpu_addr), .cpu_writedata(cpu_writedata),
        .cpu_writectrl(cpu_writectrl), .cpu_readctrl(cpu_readctrl), .mem_addr(mem_addr),
        .mem_writedata(mem_writedata), .mem_writectrl(mem_writectrl),
        .mem_readctrl(mem_readctrl), .mem_empty(mem_empty), .clken(clken), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic push_word(input logic [31:0] w);
        img.push_back(w[7:0]);
        img.push_back(w[15:8]);
        img.push_back(w[23:16]);
        img.push_back(w[31:24]);
    endtask

    // Image = length word, data words, then (optionally) XOR trailer; all little-endian.
    task automatic finish_image();
        img.delete();
        push_word(32'(words.size()));
        foreach (words[i]) push_word(words[i]);
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (words.size() != 0) begin
            logic [31:0] x;
            x = 32'd0;
            foreach (words[i]) x = x ^ words[i];
            push_word(bad_trailer ? 32'd0 : x);
        end
`endif
    endtask

    task automatic random_image(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
        finish_image();
    endtask

    task automatic randomize_cpu();
        cpu_addr      = $urandom;
        cpu_writedata = $urandom;
        cpu_writectrl = 1'($urandom);
        cpu_readctrl  = 1'($urandom);
    endtask

    task automatic do_reset(input logic boot);
        @(negedge clk);
        rst_n = 1'b0;
        boot_en = boot;
        empty = 1'b1;
        uart_in = 8'h00;
        randomize_cpu();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic post_check(input bit exp_err);
        for (int i = 0; i < 6; i++) begin
            empty = 1'($urandom);
            uart_in = $urandom;
            randomize_cpu();
            #1;
            checks++;
            if (exp_err) begin
                if (err !== 1'b1 || clken !== 1'b0 || busy !== 1'b0 || rdreq !== 1'b0 ||
                    mem_writectrl !== 1'b0) begin
                    failures++;
                    $display("FAIL err_hold: err=%b clken=%b busy=%b rdreq=%b wr=%b required 1 0 0 0 0",
                             err, clken, busy, rdreq, mem_writectrl);
                end
            end else if (clken !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || rdreq !== 1'b0 ||
                         mem_addr !== cpu_addr || mem_writedata !== cpu_writedata ||
                         mem_writectrl !== cpu_writectrl || mem_readctrl !== cpu_readctrl ||
                         mem_empty !== empty) begin
                failures++;
                $display("FAIL run_passthru: addr=%h/%h data=%h/%h wc=%b/%b rc=%b/%b me=%b/%b ck=%b bz=%b",
                         mem_addr, cpu_addr, mem_writedata, cpu_writedata, mem_writectrl,
                         cpu_writectrl, mem_readctrl, cpu_readctrl, mem_empty, empty, clken, busy);
            end
            @(negedge clk);
        end
    endtask

    // Feeds img through a FIFO model with random stalls after every pop; expects words[] written in order.
    task automatic run_load(input string name, input int exp_pops, input int min_stall,
                            input int max_stall, input bit exp_err, input int exp_cycles);
        int idx = 0;
        int wr = 0;
        int cyc = 0;
        int stall = 0;
        while (cyc < 2000 && clken !== 1'b1 && err !== 1'b1) begin
            if (stall > 0) begin
                empty = 1'b1;
                stall--;
            end else if (idx < img.size()) begin
                empty = 1'b0;
                uart_in = img[idx];
            end else begin
                empty = 1'b1;
            end
            randomize_cpu();
            #1;
            checks++;
            if (busy !== 1'b1 || (empty && rdreq !== 1'b0) || mem_readctrl !== 1'b0 ||
                mem_empty !== 1'b1) begin
                failures++;
                $display("FAIL %s load_ctrl cyc=%0d: busy=%b empty=%b rdreq=%b rc=%b me=%b", name,
                         cyc, busy, empty, rdreq, mem_readctrl, mem_empty);
            end
            if (mem_writectrl === 1'b1) begin
                checks++;
                if (wr >= words.size()) begin
                    failures++;
                    $display("FAIL %s extra_write: addr=%h data=%h required none", name, mem_addr,
                             mem_writedata);
                end else if (mem_addr !== BASE + 32'(4 * wr) || mem_writedata !== words[wr]) begin
                    failures++;
                    $display("FAIL %s write%0d: addr=%h data=%h required addr=%h data=%h", name, wr,
                             mem_addr, mem_writedata, BASE + 32'(4 * wr), words[wr]);
                end
                wr++;
            end
            if (rdreq === 1'b1) begin
                idx++;
                stall = int'($urandom_range(max_stall, min_stall));
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 2000 || err !== exp_err || clken !== !exp_err) begin
            failures++;
            $display("FAIL %s end_state: cyc=%0d err=%b clken=%b required err=%b", name, cyc, err,
                     clken, exp_err);
        end
        checks++;
        if (wr != words.size() || idx != exp_pops) begin
            failures++;
            $display("FAIL %s counts: writes=%0d pops=%0d required writes=%0d pops=%0d", name, wr,
                     idx, words.size(), exp_pops);
        end
        if (exp_cycles >= 0) begin
            checks++;
            if (cyc != exp_cycles) begin
                failures++;
                $display("FAIL %s latency: cycles=%0d required %0d", name, cyc, exp_cycles);
            end
        end
        post_check(exp_err);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        boot_en = 1'b1;
        empty = 1'b0;
        uart_in = 8'hA5;
        randomize_cpu();
        #1;
        checks++;
        if (rdreq !== 1'b0 || clken !== 1'b0 || busy !== 1'b1 || err !== 1'b0 ||
            mem_writectrl !== 1'b0 || mem_readctrl !== 1'b0 || mem_empty !== 1'b1 ||
            mem_addr !== BASE) begin
            failures++;
            $display("FAIL reset: rdreq=%b clken=%b busy=%b err=%b wc=%b rc=%b me=%b addr=%h", rdreq,
                     clken, busy, err, mem_writectrl, mem_readctrl, mem_empty, mem_addr);
        end
        @(posedge clk);
    endtask

    task automatic test_no_boot();
        do_reset(1'b0);
        checks++;
        if (clken !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL noboot_idle: clken=%b busy=%b required 0 1", clken, busy);
        end
        @(negedge clk);
        cpu_addr = 32'h4;
        cpu_writedata = 32'hCAFE_F00D;
        cpu_writectrl = 1'b1;
        cpu_readctrl = 1'b0;
        #1;
        checks++;
        if (clken !== 1'b1 || busy !== 1'b0 || mem_writectrl !== 1'b1 || mem_addr !== 32'h4 ||
            mem_writedata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL noboot_store: clken=%b busy=%b wc=%b addr=%h data=%h", clken, busy,
                     mem_writectrl, mem_addr, mem_writedata);
        end
        @(negedge clk);
        post_check(1'b0);
    endtask

    task automatic test_fixed_image();
        words.delete();
        words.push_back(32'h1234_5678);
        words.push_back(32'hDEAD_BEEF);
        finish_image();
        do_reset(1'b1);
        run_load("fixed", img.size(), 0, 0, 1'b0, 1 + 4 + 5 * 2 + CsumCyc);
        do_reset(1'b1);
        run_load("fixed_stall3", img.size(), 3, 3, 1'b0, -1);
    endtask

    task automatic test_len_err();
        words.delete();
        img.delete();
        push_word(32'h0000_8001);
        push_word($urandom);
        do_reset(1'b1);
        run_load("len_err", 4, 0, 1, 1'b1, -1);
        words.delete();
        img.delete();
        push_word(32'h0000_8000);
        push_word($urandom);
        do_reset(1'b1);
        // At exactly MAX_WORDS the length is accepted; stop after the first word has been written.
        run_load_partial_max();
    endtask

    task automatic run_load_partial_max();
        int pops = 0;
        bit wrote = 1'b0;
        for (int c = 0; c < 40 && !wrote; c++) begin
            empty = (pops >= img.size());
            if (!empty) uart_in = img[pops];
            #1;
            if (mem_writectrl === 1'b1) wrote = 1'b1;
            if (rdreq === 1'b1) pops++;
            @(negedge clk);
        end
        checks++;
        if (!wrote || err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL len_max: wrote=%b err=%b busy=%b required 1 0 1", wrote, err, busy);
        end
    endtask

    task automatic test_len_zero();
        words.delete();
        finish_image();
        push_word($urandom);
        do_reset(1'b1);
        run_load("len_zero", 4, 0, 0, 1'b0, 5);
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        random_image(2);
        do_reset(1'b1);
        for (int c = 0; c < 40 && idx < 6; c++) begin
            empty = 1'b0;
            uart_in = img[idx];
            #1;
            if (rdreq === 1'b1) idx++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (idx != 6 || busy !== 1'b1 || clken !== 1'b0 || rdreq !== 1'b0 ||
            mem_writectrl !== 1'b0 || mem_addr !== BASE) begin
            failures++;
            $display("FAIL reset_mid: pops=%0d busy=%b clken=%b rdreq=%b wc=%b addr=%h", idx, busy,
                     clken, rdreq, mem_writectrl, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        random_image(3);
        run_load("after_reset", img.size(), 0, 0, 1'b0, 1 + 4 + 5 * 3 + CsumCyc);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            random_image(int'($urandom_range(8, 1)));
            do_reset(1'b1);
            run_load($sformatf("random%0d", t), img.size(), 0, 2, 1'b0, -1);
        end
    endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
    task automatic test_csum_bad();
        words.delete();
        words.push_back(32'h1234_5678);
        words.push_back(32'hDEAD_BEEF);
        bad_trailer = 1'b1;
        finish_image();
        bad_trailer = 1'b0;
        do_reset(1'b1);
        run_load("csum_bad", img.size(), 0, 0, 1'b1, 1 + 4 + 5 * 2 + 4);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        boot_en = 1'b0;
        empty = 1'b1;
        uart_in = 8'h00;
        randomize_cpu();
        test_reset();
        test_no_boot();
        test_fixed_image();
        test_len_err();
        test_len_zero();
        test_reset_mid();
        test_random();
`ifdef BOOT_LOADER_CHECKSUM_EN
        test_csum_bad();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
